// File: rtl/ddr_transmitter_24bit.sv
// ddr_transmitter_24bit: FIFO-buffered 24-bit word transmitter onto a 12-bit DDR bus,
// with a training-pattern phase after reset or on request.
module ddr_transmitter_24bit #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          TRAIN_CYCLES = 64,
  parameter logic [23:0] IDLE_WORD    = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_train_req,
  output logic [11:0] o_ddr_out,
  output logic        o_ddr_clk_out,
  output logic        o_tx_valid,
  output logic        o_training,
  output logic [15:0] o_gap_cnt,
  output logic        o_dbg_tx,
  output logic        o_dbg_pop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TRAIN_CYCLES + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(TRAIN_CYCLES - 1);
  localparam logic [AW:0] C_FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic {S_TRAIN, S_DATA} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [23:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic r_ready_en, r_tx_valid, r_training, r_dbg_pop, r_popped;
  logic [15:0] r_gap;
  logic [11:0] r_pos, r_hi, r_neg;
  logic w_push, w_pop, w_idle;
  logic [23:0] w_word;

  assign o_ready = r_ready_en & (r_count != C_FULL);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = (r_state == S_DATA) & (r_count != '0);
  assign w_idle  = (r_state == S_DATA) & (r_count == '0);
  assign w_word  = (r_state == S_TRAIN) ? {12'h5A5, 12'hA5A} : w_pop ? r_mem[r_rptr] : IDLE_WORD;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_train_req) begin
      w_state_nxt = S_TRAIN;
      w_cnt_nxt   = C_LOAD;
    end else if (r_state == S_TRAIN) begin
      w_state_nxt = (r_cnt == '0) ? S_DATA : S_TRAIN;
      w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_TRAIN;
      r_cnt      <= C_LOAD;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
      r_tx_valid <= 1'b0;
      r_training <= 1'b1;
      r_dbg_pop  <= 1'b0;
      r_popped   <= 1'b0;
      r_gap      <= '0;
      r_pos      <= '0;
      r_hi       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wptr     <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr     <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count    <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
      r_ready_en <= 1'b1;
      r_tx_valid <= w_pop;
      r_training <= (r_state == S_TRAIN);
      r_dbg_pop  <= w_pop;
      r_popped   <= r_popped | w_pop;
      r_gap      <= (w_idle & r_popped & (r_gap != 16'hFFFF)) ? r_gap + 16'd1 : r_gap;
      r_pos      <= w_word[11:0];
      r_hi       <= w_word[23:12];
    end
  end

  // Upper half moves to the negedge register so it is stable for the whole low phase.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_neg <= '0;
    else          r_neg <= r_hi;
  end

  assign o_ddr_out     = i_clk ? r_pos : r_neg;
  assign o_ddr_clk_out = i_clk ? r_ready_en : 1'b0;
  assign o_tx_valid    = r_tx_valid;
  assign o_training    = r_training;
  assign o_gap_cnt     = r_gap;
  assign o_dbg_tx      = o_ddr_out[11];
  assign o_dbg_pop     = r_dbg_pop;
endmodule

// File: tb/tb_ddr_transmitter_24bit.sv
// tb_ddr_transmitter_24bit: directed vector table plus hand sequences for training,
// FIFO fill, streaming with retrain, reset mid-stream and GAP_CNT saturation.
module tb_ddr_transmitter_24bit;
  logic        i_clk, i_rst_n, i_valid, i_train_req;
  logic [23:0] i_data;
  logic        o_ready, o_ddr_clk_out, o_tx_valid, o_training, o_dbg_tx, o_dbg_pop;
  logic [11:0] o_ddr_out;
  logic [15:0] o_gap_cnt;
  int checks = 0;
  int errors = 0;
  logic [11:0] s_hi, s_lo;
  logic        s_ck, s_dbg, s_txv, s_trn, s_pop, s_rdy_pre, s_rdy_post;
  logic [15:0] s_gap;

  ddr_transmitter_24bit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_train_req(i_train_req), .o_ddr_out(o_ddr_out),
    .o_ddr_clk_out(o_ddr_clk_out), .o_tx_valid(o_tx_valid), .o_training(o_training),
    .o_gap_cnt(o_gap_cnt), .o_dbg_tx(o_dbg_tx), .o_dbg_pop(o_dbg_pop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic [11:0] hi;
    logic [11:0] lo;
    logic        txv;
    logic [15:0] gap;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  // One CLK cycle starting in the low phase: drive, sample high phase, sample low phase.
  task automatic step(input logic v, input logic [23:0] d, input logic tr);
    i_valid = v;
    i_data = d;
    i_train_req = tr;
    s_rdy_pre = o_ready;
    @(posedge i_clk);
    #1;
    s_hi = o_ddr_out;
    s_ck = o_ddr_clk_out;
    s_dbg = o_dbg_tx;
    @(negedge i_clk);
    #1;
    s_lo = o_ddr_out;
    s_txv = o_tx_valid;
    s_trn = o_training;
    s_pop = o_dbg_pop;
    s_gap = o_gap_cnt;
    s_rdy_post = o_ready;
    i_valid = 1'b0;
    i_train_req = 1'b0;
  endtask

  task automatic train_run(input string n);
    for (int t = 0; t < 64; t++) begin
      step(1'b0, 24'h0, 1'b0);
      chk({n, "_hi"}, s_hi, 12'hA5A);
      chk({n, "_lo"}, s_lo, 12'h5A5);
      chk({n, "_trn"}, s_trn, 1'b1);
      chk({n, "_txv"}, s_txv, 1'b0);
      chk({n, "_ck"}, s_ck, 1'b1);
    end
    step(1'b0, 24'h0, 1'b0);
    chk({n, "_end_hi"}, s_hi, 12'h000);
    chk({n, "_end_lo"}, s_lo, 12'h000);
    chk({n, "_end_trn"}, s_trn, 1'b0);
    chk({n, "_end_txv"}, s_txv, 1'b0);
  endtask

  initial begin
    vec_t vt[5];
    logic [23:0] wb[5];
    int n, e, trains, first_e;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_train_req = 1'b0;
    i_data = '0;
    vt[0] = '{1'b1, 24'h123456, 12'h000, 12'h000, 1'b0, 16'd0};
    vt[1] = '{1'b1, 24'hABCDEF, 12'h456, 12'h123, 1'b1, 16'd0};
    vt[2] = '{1'b0, 24'h000000, 12'hDEF, 12'hABC, 1'b1, 16'd0};
    vt[3] = '{1'b0, 24'h000000, 12'h000, 12'h000, 1'b0, 16'd1};
    vt[4] = '{1'b0, 24'h000000, 12'h000, 12'h000, 1'b0, 16'd2};
    wb = '{24'h111AAA, 24'h222BBB, 24'h333CCC, 24'h444DDD, 24'h555EEE};

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_out_hi", o_ddr_out, 12'h000);
    chk("rst_ck_hi", o_ddr_clk_out, 1'b0);
    chk("rst_trn", o_training, 1'b1);
    chk("rst_rdy", o_ready, 1'b0);
    chk("rst_txv", o_tx_valid, 1'b0);
    chk("rst_gap", o_gap_cnt, 16'd0);
    chk("rst_dbg", o_dbg_tx, 1'b0);
    chk("rst_pop", o_dbg_pop, 1'b0);
    @(negedge i_clk);
    #1;
    chk("rst_out_lo", o_ddr_out, 12'h000);
    i_rst_n = 1'b1;
    train_run("train0");
    chk("train0_gap", s_gap, 16'd0);

    for (int i = 0; i < 5; i++) begin
      step(vt[i].v, vt[i].d, 1'b0);
      chk($sformatf("vec%0d_hi", i), s_hi, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), s_lo, vt[i].lo);
      chk($sformatf("vec%0d_txv", i), s_txv, vt[i].txv);
      chk($sformatf("vec%0d_pop", i), s_pop, vt[i].txv);
      chk($sformatf("vec%0d_gap", i), s_gap, vt[i].gap);
      chk($sformatf("vec%0d_dbg", i), s_dbg, vt[i].hi[11]);
    end

    step(1'b1, wb[0], 1'b1);
    chk("fill_req_rdy", s_rdy_pre, 1'b1);
    chk("fill_req_hi", s_hi, 12'h000);
    chk("fill_req_gap", s_gap, 16'd3);
    for (int t = 1; t <= 64; t++) begin
      step(1'b1, wb[t < 4 ? t : 4], 1'b0);
      chk($sformatf("fill_rdy_t%0d", t), s_rdy_pre, t <= 3);
      chk("fill_hi", s_hi, 12'hA5A);
      chk("fill_lo", s_lo, 12'h5A5);
      chk("fill_trn", s_trn, 1'b1);
      chk("fill_txv", s_txv, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      step(k < 2, wb[4], 1'b0);
      if (k < 2) chk($sformatf("drain_rdy_pre%0d", k), s_rdy_pre, k == 1);
      chk($sformatf("drain_word%0d", k), {s_lo, s_hi}, wb[k]);
      chk($sformatf("drain_txv%0d", k), s_txv, 1'b1);
    end
    chk("drain_rdy_after_pop", s_rdy_post, 1'b1);
    step(1'b0, 24'h0, 1'b0);
    chk("drain_idle_txv", s_txv, 1'b0);
    chk("drain_idle_gap", s_gap, 16'd4);

    n = 1;
    e = 1;
    trains = 0;
    first_e = 0;
    for (int s = 0; s < 110; s++) begin
      step(n <= 16, 24'(n), s == 5);
      if (s_rdy_pre && n <= 16) n++;
      if (s_txv) begin
        chk("stream_word", {s_lo, s_hi}, 24'(e));
        e++;
      end
      if (s_trn) begin
        trains++;
        if (first_e == 0) first_e = e;
      end
    end
    chk("stream_count", e, 17);
    chk("stream_trains", trains, 64);
    chk("stream_req_word", first_e, 6);

    step(1'b1, 24'hC0FFEE, 1'b1);
    step(1'b1, 24'hBADBAD, 1'b0);
    chk("mid_lo_before", o_ddr_out, 12'h5A5);
    chk("mid_rdy_before", o_ready, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_out_lo", o_ddr_out, 12'h000);
    chk("mid_rst_rdy", o_ready, 1'b0);
    chk("mid_rst_ck_lo", o_ddr_clk_out, 1'b0);
    @(posedge i_clk);
    #1;
    chk("mid_rst_out_hi", o_ddr_out, 12'h000);
    chk("mid_rst_ck_hi", o_ddr_clk_out, 1'b0);
    chk("mid_rst_gap", o_gap_cnt, 16'd0);
    chk("mid_rst_trn", o_training, 1'b1);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    train_run("train1");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 24'h0, 1'b0);
      chk("mid_empty_txv", s_txv, 1'b0);
      chk("mid_empty_gap", s_gap, 16'd0);
    end

    step(1'b1, 24'h00F00D, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    chk("sat_word", {s_lo, s_hi}, 24'h00F00D);
    chk("sat_gap0", s_gap, 16'd0);
    repeat (65534) @(posedge i_clk);
    #1;
    chk("sat_gap_fffe", o_gap_cnt, 16'hFFFE);
    repeat (4466) @(posedge i_clk);
    #1;
    chk("sat_gap_ffff", o_gap_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
